// File: rtl/mul_exhaustive_checker_pkg.sv
// Shared types and defaults for the exhaustive multiplier checker.
package mul_exhaustive_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_SETTLE = 1;

endpackage

// File: rtl/mul_vec_gen.sv
// Operand pair generator: b is the inner loop, a advances when b wraps.
module mul_vec_gen #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic             o_last_vec
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_clear) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_advance) begin
            r_b <= r_b + WIDTH'(1);
            if (&r_b)
                r_a <= r_a + WIDTH'(1);
        end
    end

    assign o_a        = r_a;
    assign o_b        = r_b;
    assign o_last_vec = (&r_a) & (&r_b);

endmodule

// File: rtl/mul_exhaustive_checker.sv
// Walks every operand pair through an external combinational multiplier,
// compares against an internal product and records mismatches.
module mul_exhaustive_checker
    import mul_exhaustive_checker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    input  logic [2*WIDTH-1:0] dut_o,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   err_count,
    output logic               err_flag,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b,
    output logic [2*WIDTH-1:0] first_err_o
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t             r_state;
    logic [SW-1:0]      r_settle;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH:0]   r_err_count;
    logic [WIDTH-1:0]   r_first_a;
    logic [WIDTH-1:0]   r_first_b;
    logic [2*WIDTH-1:0] r_first_o;

    logic               w_start_ok;
    logic               w_advance;
    logic               w_last;
    logic               w_mismatch;
    logic [2*WIDTH-1:0] w_prod;

    assign w_start_ok = start && (r_state == IDLE || r_state == FINISH);
    assign w_advance  = (r_state == CHECK) && !w_last;
    assign w_prod     = {{WIDTH{1'b0}}, dut_a} * {{WIDTH{1'b0}}, dut_b};
    assign w_mismatch = (dut_o != w_prod);

    mul_vec_gen #(.WIDTH(WIDTH)) u_vec_gen (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clear    (w_start_ok),
        .i_advance  (w_advance),
        .o_a        (dut_a),
        .o_b        (dut_b),
        .o_last_vec (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_settle    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_first_a   <= '0;
            r_first_b   <= '0;
            r_first_o   <= '0;
        end else begin
            case (r_state)
                IDLE, FINISH: begin
                    if (start) begin
                        r_state     <= HOLD;
                        r_settle    <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err_count <= '0;
                        r_first_a   <= '0;
                        r_first_b   <= '0;
                        r_first_o   <= '0;
                    end
                end
                HOLD: begin
                    // r_settle counts HOLD cycles already spent on this pair
                    if (r_settle == SW'(SETTLE - 1)) begin
                        r_state  <= CHECK;
                        r_settle <= '0;
                    end else begin
                        r_settle <= r_settle + SW'(1);
                    end
                end
                CHECK: begin
                    if (w_mismatch) begin
                        r_err_count <= r_err_count + (2*WIDTH+1)'(1);
                        if (r_err_count == '0) begin
                            r_first_a <= dut_a;
                            r_first_b <= dut_b;
                            r_first_o <= dut_o;
                        end
                    end
                    if (w_last) begin
                        r_state <= FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state  <= HOLD;
                        r_settle <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err_count   = r_err_count;
    assign err_flag    = (r_err_count != '0);
    assign first_err_a = r_first_a;
    assign first_err_b = r_first_b;
    assign first_err_o = r_first_o;

endmodule

// File: tb/tb_mul_exhaustive_checker.sv
// Bench: a WIDTH=4/SETTLE=1 checker against a fault-injectable multiplier,
// plus a WIDTH=2/SETTLE=3 checker whose operand sequence is tracked per cycle.
module tb_mul_exhaustive_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A: WIDTH=4, SETTLE=1
    logic       start_a = 1'b0;
    logic [3:0] a_a, b_a, fa_a, fb_a;
    logic [7:0] o_a, fo_a;
    logic [8:0] cnt_a;
    logic       busy_a, done_a, flag_a;

    // instance B: WIDTH=2, SETTLE=3
    logic       start_b = 1'b0;
    logic [1:0] a_b, b_b, fa_b, fb_b;
    logic [3:0] o_b, fo_b;
    logic [4:0] cnt_b;
    logic       busy_b, done_b, flag_b;

    mul_exhaustive_checker #(.WIDTH(4), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_a(a_a), .dut_b(b_a), .dut_o(o_a),
        .busy(busy_a), .done(done_a), .err_count(cnt_a), .err_flag(flag_a),
        .first_err_a(fa_a), .first_err_b(fb_a), .first_err_o(fo_a)
    );

    mul_exhaustive_checker #(.WIDTH(2), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_a(a_b), .dut_b(b_b), .dut_o(o_b),
        .busy(busy_b), .done(done_b), .err_count(cnt_b), .err_flag(flag_b),
        .first_err_a(fa_b), .first_err_b(fb_b), .first_err_o(fo_b)
    );

    // multiplier models: A can be corrupted per pair or have bit 0 stuck low
    logic [7:0] mask [256];
    bit         stuck = 1'b0;

    always_comb begin
        o_a = {4'b0, a_a} * {4'b0, b_a};
        if (stuck) o_a = o_a & 8'hFE;
        else       o_a = o_a ^ mask[{a_a, b_a}];
    end
    assign o_b = {2'b0, a_b} * {2'b0, b_b};

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt;
    logic [3:0] exp_fa, exp_fb;
    logic [7:0] exp_fo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Build the fault pattern and predict what the checker must report.
    task automatic set_faults(input bit stk, input int one_in);
        int prod, seen;
        bit found;
        stuck = stk;
        for (int i = 0; i < 256; i++)
            mask[i] = (one_in > 0 && $urandom_range(one_in - 1, 0) == 0) ?
                      8'($urandom_range(255, 1)) : 8'h00;
        exp_cnt = 0; found = 0;
        exp_fa = 0; exp_fb = 0; exp_fo = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                prod = a * b;
                seen = stk ? (prod & 'hFE) : (prod ^ int'(mask[a*16+b]));
                if (seen != prod) begin
                    exp_cnt++;
                    if (!found) begin
                        found = 1; exp_fa = 4'(a); exp_fb = 4'(b); exp_fo = 8'(seen);
                    end
                end
            end
    endtask

    task automatic run_a(input string tag);
        int n;
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        chk({tag, "_busy_rise"}, 64'(busy_a), 1);
        chk({tag, "_done_clr"},  64'(done_a), 0);
        chk({tag, "_cnt_clr"},   64'(cnt_a), 0);
        chk({tag, "_ops_clr"},   64'({a_a, b_a}), 0);
        n = 0;
        while (done_a !== 1'b1 && n < 2000) begin
            @(posedge clk); #1 n++;
            start_a = (n == 10);   // a second start mid-run must be ignored
        end
        start_a = 1'b0;
        chk({tag, "_len"},    64'(n), 512);
        chk({tag, "_busy"},   64'(busy_a), 0);
        chk({tag, "_cnt"},    64'(cnt_a), 64'(exp_cnt));
        chk({tag, "_flag"},   64'(flag_a), 64'(exp_cnt != 0));
        chk({tag, "_first"},  64'({fa_a, fb_a, fo_a}), 64'({exp_fa, exp_fb, exp_fo}));
        chk({tag, "_last_ops"}, 64'({a_a, b_a}), 64'(8'hFF));
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_hold"}, 64'({done_a, busy_a, cnt_a, fa_a, fb_a, fo_a}),
            64'({1'b1, 1'b0, 9'(exp_cnt), exp_fa, exp_fb, exp_fo}));
    endtask

    initial begin
        set_faults(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", 64'({busy_a, done_a, cnt_a, flag_a, a_a, b_a, fa_a, fb_a, fo_a}), 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_rst", 64'({busy_a, done_a, busy_b, done_b}), 0);

        set_faults(0, 20);
        run_a("rand_faults");

        set_faults(1, 0);
        run_a("stuck_bit0");
        chk("stuck_expect", 64'(exp_cnt), 64);

        // asynchronous reset partway through a run
        set_faults(0, 8);
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrun_rst", 64'({busy_a, done_a, cnt_a, flag_a, a_a, b_a, fa_a, fb_a, fo_a}), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_midrun", 64'({busy_a, done_a}), 0);
        set_faults(0, 0);
        run_a("clean");

        // WIDTH=2, SETTLE=3: pair k/4 presented during run cycle k
        @(negedge clk); start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int k = 0; k < 64; k++) begin
            chk("b_ops", 64'({a_b, b_b}), 64'({2'((k / 4) / 4), 2'((k / 4) % 4)}));
            chk("b_busy", 64'({busy_b, done_b}), 64'(2'b10));
            @(posedge clk); #1;
        end
        chk("b_done", 64'({busy_b, done_b}), 64'(2'b01));
        chk("b_cnt", 64'({cnt_b, flag_b}), 0);
        chk("b_last_ops", 64'({a_b, b_b}), 64'(4'hF));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mul_exhaustive_checker.md
MUL_EXHAUSTIVE_CHECKER -- requirements
Module: mul_exhaustive_checker

Interface
REQ-001 Parameter WIDTH, default 8: operand width of the multiplier under test. Legal range 2..12.
REQ-002 Parameter SETTLE, default 1: clock cycles each operand pair is held before its product is sampled. Must be at least 1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin an exhaustive run.
REQ-006 dut_a  output  WIDTH  operand A driven to the combinational multiplier.
REQ-007 dut_b  output  WIDTH  operand B driven to the combinational multiplier.
REQ-008 dut_o  input  2*WIDTH  product returned by the multiplier.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  high from run completion until the next accepted start.
REQ-011 err_count  output  2*WIDTH+1  number of mismatching vectors in the current or last run.
REQ-012 err_flag  output  1  high when err_count is non-zero.
REQ-013 first_err_a, first_err_b  output  WIDTH each  operands of the first mismatch.
REQ-014 first_err_o  output  2*WIDTH  DUT product of the first mismatch.

Function
REQ-015 The FSM SHALL have four states: IDLE, HOLD, CHECK, FINISH.
- IDLE -> HOLD on start.
- HOLD -> CHECK after SETTLE-1 further cycles; when SETTLE=1, HOLD lasts exactly one cycle.
- CHECK -> HOLD on the next vector.
- CHECK -> FINISH after the last vector.
- FINISH -> HOLD on start.
REQ-016 When start is accepted, the block SHALL clear dut_a, dut_b, err_count, err_flag and all first_err_* outputs to 0, and SHALL deassert done.
REQ-017 busy SHALL be high in HOLD and CHECK only. busy SHALL rise in the cycle after start is sampled.
REQ-018 Operands SHALL advance with dut_a as the outer loop and dut_b as the inner loop, each running 0..2^WIDTH-1. Advancing SHALL follow this rule:
- dut_b wraps to 0 when it reaches its maximum.
- dut_a increments only when dut_b wraps.
REQ-019 Each operand pair SHALL remain stable for exactly SETTLE+1 cycles: SETTLE cycles in HOLD plus 1 cycle in CHECK.
REQ-020 In CHECK, the block SHALL compare dut_o against the unsigned product dut_a*dut_b, computed internally at full 2*WIDTH width.
REQ-021 On a mismatch:
- err_count SHALL increment by 1.
- If err_count was 0, first_err_a/b/o SHALL capture dut_a, dut_b and dut_o.
REQ-022 err_count SHALL NOT saturate, since its width covers all 2^(2*WIDTH) vectors.
REQ-023 The last vector is a = b = 2^WIDTH-1. After its CHECK cycle:
- done SHALL rise on the next cycle.
- busy SHALL fall on the same cycle.
- The FSM SHALL enter FINISH.
- dut_a and dut_b SHALL hold their last values.
REQ-024 Total run length from the cycle after start to the rising edge of done SHALL be 2^(2*WIDTH)*(SETTLE+1) cycles. For WIDTH=8 and SETTLE=1 this is 131072 cycles.
REQ-025 start SHALL be ignored while busy is high.
REQ-026 Results (err_count, err_flag, first_err_*) SHALL hold stable in FINISH.
REQ-027 err_flag SHALL be combinationally equal to (err_count != 0).

Reset
REQ-028 Asserting rst at any time, including mid-run, SHALL immediately force:
- The FSM to IDLE.
- All outputs to 0, including busy and done.
REQ-029 After rst is deasserted, the block SHALL remain in IDLE until start is sampled high.

Structure
REQ-030 A shared package SHALL hold:
- The FSM state enum (IDLE, HOLD, CHECK, FINISH).
- The default WIDTH and SETTLE constants.
REQ-031 The operand counter SHALL be a sub-module, mul_vec_gen, providing:
- The a/b registers.
- clear and advance inputs.
- A last_vec output.
REQ-032 The FSM, settle counter, comparator and error registers SHALL reside in mul_exhaustive_checker.

Verification
REQ-033 Correct DUT, WIDTH=8, SETTLE=1, single start pulse -> done rises after 131072 cycles; err_count=0; err_flag=0.
REQ-034 DUT with bit 0 of the product stuck at 0, WIDTH=4 -> err_count=64 (products with odd value); first_err_a=1, first_err_b=1, first_err_o=0.
REQ-035 WIDTH=2, SETTLE=3, correct DUT -> done after 64 cycles; dut_a/dut_b constant over each 4-cycle window; sequence (0,0),(0,1)...(3,3).
REQ-036 rst pulsed at cycle 500 of a WIDTH=8 run -> all outputs 0 within the same cycle; a new start then completes a full run with err_count=0.
REQ-037 start pulsed again at cycle 10 of a run -> ignored; run completes at the nominal length; a start in FINISH restarts and clears results.
